m68k_bus_sequencer: RTL and testbench
=====================================

Name: m68k_bus_sequencer

Overview:
- Queued 68000 bus-cycle engine in the Pi fast-clock domain.
- Accepts byte/word/longword requests into a parametrised FIFO and runs them in order as 68000 S0–S7 bus cycles, timed from the synchronised M68K_CLK.
- Adds posted-write queuing, longword splitting, bus-error and timeout termination, and in-order per-request responses. Sits between the Pi register interface and the bus latches.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of two, ≥2)
SYNC_STAGES, 3, synchroniser flops on M68K_CLK, DTACK_n, BERR_n, VPA_n (≥2)
TIMEOUT_CYC, 1023, M68K_CLK falling edges in wait state before timeout error

Ports:
PI_CLK  in  1  sole clock (fast Pi clock)
PI_RST  in  1  synchronous reset, active-high
REQ_VALID  in  1  request push
REQ_READY  out  1  FIFO not full
REQ_ADDR  in  24  byte address
REQ_WDATA  in  32  write data; word/byte use low bits
REQ_SIZE  in  2  0=byte, 1=word, 2=long; 3 is reserved and treated as word
REQ_RW  in  1  1=read
REQ_FC  in  3  function code
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  32  read data, zero-extended
RSP_ERR  out  2  0=ok, 1=BERR, 2=timeout, 3=misaligned
FIFO_LEVEL  out  $clog2(FIFO_DEPTH+1)  queued entries
BUSY  out  1  bus cycle in progress or FIFO non-empty
M68K_CLK  in  1  7 MHz bus clock, sampled as data
M68K_A  out  23  A23..A1
M68K_FC  out  3  function code
M68K_D_OUT  out  16  write data
M68K_D_OE  out  1  data driver enable
M68K_D_IN  in  16  read data
M68K_AS_n, M68K_UDS_n, M68K_LDS_n  out  1  strobes
M68K_RW  out  1  1=read
M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n  in  1  terminations
M68K_E  out  1  E clock
M68K_VMA_n  out  1  valid memory address

Behaviour:

Reset values (during and after PI_RST):
- Strobes, VMA_n, RW = 1; D_OE = 0; E = 0; RSP_VALID = 0; FIFO empty; E counter = 0; state IDLE.

Reset mid-operation:
- Strobes negate on the next PI_CLK cycle.
- Queued and in-flight requests are dropped with no response.

Clock edge detection:
- M68K_CLK passes through SYNC_STAGES flops.
- A one-cycle `rise` or `fall` pulse is derived from the last two stages.
- All bus-state transitions occur only on these pulses.
- DTACK_n, BERR_n and VPA_n are synchronised the same way and evaluated on `fall`.

FIFO:
- Push when REQ_VALID && REQ_READY.
- A push while full is ignored.
- Push and pop in the same cycle leave FIFO_LEVEL unchanged.

Misaligned requests:
- Word or long with ADDR[0]=1: no bus cycle is run.
- RSP_VALID fires 1 PI_CLK after pop, with RSP_ERR=3.

Strobe selection:
- Byte with A0=0 → UDS; A0=1 → LDS.
- Word → both strobes.
- Byte write drives WDATA[7:0] on both halves.
- Byte read returns the selected half in RDATA[7:0].

Longword:
- Runs as two word cycles: ADDR (high word, WDATA[31:16]) then ADDR+2.
- AS negates between the two cycles.
- One response after the second cycle.
- An error on the first cycle skips the second.

State machine:
- IDLE, `fall` with head entry valid → S1: pop, drive A/FC; RW still 1.
- S1, `rise` → S2: AS=0, RW=op_rw; reads assert UDS/LDS.
- S2, `fall` → S3: writes set D_OE=1.
- S3, `rise` → S4: writes assert UDS/LDS.
- S4/Sw, `fall`:
  - BERR low → S5 with err=1 (BERR wins over DTACK).
  - Else DTACK low → S5.
  - Else if VPA low and E count==2 → VMA_n=0.
  - Else if VMA_n low and E count==8 → S5.
  - Else stay in Sw and increment timeout; reaching TIMEOUT_CYC → S5 with err=2.
- S5, `rise` → S6.
- S6, `fall` → S7: latch D_IN for reads; negate AS/UDS/LDS; VMA_n=1.
- S7, `rise` → D_OE=0, RW=1. Then IDLE, or S1 for the second longword half.
- RSP_VALID pulses on the PI_CLK cycle after the completing S7 `rise`.

E clock:
- Counter 0..9 advances on every `fall`, wrapping 9→0.
- E goes high when count becomes 6 and low when it wraps to 0 (6 clocks low, 4 high).

Test Plan:
- Word read at 0x00BFE000, DTACK low in S4 → AS low for 3 M68K_CLK; RSP_RDATA=D_IN; RSP_ERR=0; both strobes asserted from S2.
- Long write 0x12345678 to 0x000100 → two cycles: A=0x80 with D=0x1234, then A=0x81 with D=0x5678; UDS/LDS first asserted in S4; one RSP.
- Byte read 0x000001 with VPA low, no DTACK → VMA_n low at E count 2, completion at count 8, only LDS asserted.
- No DTACK, TIMEOUT_CYC=15 → RSP_ERR=2 after 15 wait `fall` edges; BERR and DTACK both low → RSP_ERR=1.
- Push 5 requests at FIFO_DEPTH=4 with the bus stalled → REQ_READY=0 after the 4th; 5th ignored; FIFO_LEVEL=4; word at odd address → RSP_ERR=3 with no AS.
- PI_RST asserted in Sw → strobes high next cycle, FIFO_LEVEL=0, no RSP_VALID.

Source files
------------

// File: rtl/m68k_bus_sequencer.sv
// Queued 68000 bus-cycle engine running in the fast Pi clock domain.
// Requests are buffered in a FIFO and replayed as S0-S7 bus cycles paced by the synchronised M68K_CLK.
module m68k_bus_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                              PI_CLK,
    input  logic                              PI_RST,
    input  logic                              REQ_VALID,
    output logic                              REQ_READY,
    input  logic [23:0]                       REQ_ADDR,
    input  logic [31:0]                       REQ_WDATA,
    input  logic [1:0]                        REQ_SIZE,
    input  logic                              REQ_RW,
    input  logic [2:0]                        REQ_FC,
    output logic                              RSP_VALID,
    output logic [31:0]                       RSP_RDATA,
    output logic [1:0]                        RSP_ERR,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_LEVEL,
    output logic                              BUSY,
    input  logic                              M68K_CLK,
    output logic [22:0]                       M68K_A,
    output logic [2:0]                        M68K_FC,
    output logic [15:0]                       M68K_D_OUT,
    output logic                              M68K_D_OE,
    input  logic [15:0]                       M68K_D_IN,
    output logic                              M68K_AS_n,
    output logic                              M68K_UDS_n,
    output logic                              M68K_LDS_n,
    output logic                              M68K_RW,
    input  logic                              M68K_DTACK_n,
    input  logic                              M68K_BERR_n,
    input  logic                              M68K_VPA_n,
    output logic                              M68K_E,
    output logic                              M68K_VMA_n
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7} state_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        rw;
        logic [2:0]  fc;
    } req_t;

    req_t fifo_mem [FIFO_DEPTH];
    req_t head_s;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dtack_sync_q, dtack_sync_d;
    logic [SYNC_STAGES-1:0] berr_sync_q, berr_sync_d, vpa_sync_q, vpa_sync_d;
    logic rise_s, fall_s, dtack_s, berr_s, vpa_s, push_s, pop_s, uds_sel_s, lds_sel_s;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d, busy_q, busy_d;
    logic [3:0]        e_cnt_q, e_cnt_d;
    logic              e_q, e_d, vma_n_q, vma_n_d;
    logic              as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
    logic              rw_q, rw_d, d_oe_q, d_oe_d;
    logic [22:0]       a_q, a_d;
    logic [2:0]        fc_q, fc_d;
    logic [15:0]       d_out_q, d_out_d;
    logic              op_rw_q, op_rw_d, op_long_q, op_long_d, op_byte_q, op_byte_d;
    logic              op_a0_q, op_a0_d, half_q, half_d;
    logic [15:0]       op_wlo_q, op_wlo_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    // Synchroniser shift and edge/termination decode from the two oldest stages
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], M68K_CLK};
        dtack_sync_d = {dtack_sync_q[SYNC_STAGES-2:0], M68K_DTACK_n};
        berr_sync_d  = {berr_sync_q[SYNC_STAGES-2:0], M68K_BERR_n};
        vpa_sync_d   = {vpa_sync_q[SYNC_STAGES-2:0], M68K_VPA_n};
        rise_s  = clk_sync_q[SYNC_STAGES-2] & ~clk_sync_q[SYNC_STAGES-1];
        fall_s  = ~clk_sync_q[SYNC_STAGES-2] & clk_sync_q[SYNC_STAGES-1];
        dtack_s = dtack_sync_q[SYNC_STAGES-1];
        berr_s  = berr_sync_q[SYNC_STAGES-1];
        vpa_s   = vpa_sync_q[SYNC_STAGES-1];
    end

    // Request FIFO bookkeeping
    always_comb begin
        head_s    = fifo_mem[rd_ptr_q];
        push_s    = REQ_VALID & ready_q;
        wr_ptr_d  = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + LVL_W'(push_s) - LVL_W'(pop_s);
        ready_d   = (count_d != LVL_W'(FIFO_DEPTH));
        busy_d    = (state_d != ST_IDLE) || (count_d != {LVL_W{1'b0}});
        uds_sel_s = ~op_byte_q | ~op_a0_q;
        lds_sel_s = ~op_byte_q | op_a0_q;
    end

    // Bus-cycle sequencer and E-clock divider
    always_comb begin
        state_d = state_q;   e_cnt_d = e_cnt_q;   e_d = e_q;       vma_n_d = vma_n_q;
        as_n_d  = as_n_q;    uds_n_d = uds_n_q;   lds_n_d = lds_n_q;
        rw_d    = rw_q;      d_oe_d  = d_oe_q;    a_d = a_q;       fc_d = fc_q;
        d_out_d = d_out_q;   op_rw_d = op_rw_q;   op_long_d = op_long_q;
        op_byte_d = op_byte_q; op_a0_d = op_a0_q; op_wlo_d = op_wlo_q; half_d = half_q;
        err_d   = err_q;     rdata_d = rdata_q;   tmo_d = tmo_q;   pop_s = 1'b0;
        rsp_valid_d = 1'b0;  rsp_err_d = rsp_err_q; rsp_rdata_d = rsp_rdata_q;

        if (fall_s) begin
            e_cnt_d = (e_cnt_q == 4'd9) ? 4'd0 : e_cnt_q + 4'd1;
            if (e_cnt_d == 4'd6) begin
                e_d = 1'b1;
            end else if (e_cnt_d == 4'd0) begin
                e_d = 1'b0;
            end else begin
                e_d = e_q;
            end
        end else begin
            e_cnt_d = e_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s && (count_q != {LVL_W{1'b0}})) begin
                    pop_s     = 1'b1;
                    op_rw_d   = head_s.rw;
                    op_long_d = (head_s.size == 2'd2);
                    op_byte_d = (head_s.size == 2'd0);
                    op_a0_d   = head_s.addr[0];
                    op_wlo_d  = head_s.wdata[15:0];
                    half_d    = 1'b0;
                    err_d     = 2'd0;
                    rdata_d   = 32'd0;
                    tmo_d     = {TMO_W{1'b0}};
                    if ((head_s.size != 2'd0) && head_s.addr[0]) begin
                        // Misaligned word/long: answer straight away, the bus is never touched
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 2'd3;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d = ST_S1;
                        a_d     = head_s.addr[23:1];
                        fc_d    = head_s.fc;
                        if (head_s.size == 2'd2) begin
                            d_out_d = head_s.wdata[31:16];
                        end else if (head_s.size == 2'd0) begin
                            d_out_d = {head_s.wdata[7:0], head_s.wdata[7:0]};
                        end else begin
                            d_out_d = head_s.wdata[15:0];
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1: begin
                if (rise_s) begin
                    state_d = ST_S2;
                    as_n_d  = 1'b0;
                    rw_d    = op_rw_q;
                    if (op_rw_q) begin
                        uds_n_d = ~uds_sel_s;
                        lds_n_d = ~lds_sel_s;
                    end else begin
                        uds_n_d = 1'b1;
                        lds_n_d = 1'b1;
                    end
                end else begin
                    state_d = ST_S1;
                end
            end
            ST_S2: begin
                if (fall_s) begin
                    state_d = ST_S3;
                    d_oe_d  = ~op_rw_q;
                end else begin
                    state_d = ST_S2;
                end
            end
            ST_S3: begin
                if (rise_s) begin
                    state_d = ST_S4;
                    if (!op_rw_q) begin
                        uds_n_d = ~uds_sel_s;
                        lds_n_d = ~lds_sel_s;
                    end else begin
                        uds_n_d = uds_n_q;
                        lds_n_d = lds_n_q;
                    end
                end else begin
                    state_d = ST_S3;
                end
            end
            ST_S4: begin
                if (!fall_s) begin
                    state_d = ST_S4;
                end else if (!berr_s) begin
                    state_d = ST_S5;
                    err_d   = 2'd1;
                end else if (!dtack_s) begin
                    state_d = ST_S5;
                end else if (!vpa_s && (e_cnt_q == 4'd2)) begin
                    vma_n_d = 1'b0;
                end else if (!vma_n_q && (e_cnt_q == 4'd8)) begin
                    state_d = ST_S5;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                        state_d = ST_S5;
                        err_d   = 2'd2;
                    end else begin
                        state_d = ST_S4;
                    end
                end
            end
            ST_S5: begin
                state_d = rise_s ? ST_S6 : ST_S5;
            end
            ST_S6: begin
                if (fall_s) begin
                    state_d = ST_S7;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    vma_n_d = 1'b1;
                    if (!op_rw_q) begin
                        rdata_d = rdata_q;
                    end else if (op_long_q) begin
                        if (half_q) begin
                            rdata_d[15:0]  = M68K_D_IN;
                        end else begin
                            rdata_d[31:16] = M68K_D_IN;
                        end
                    end else if (op_byte_q) begin
                        rdata_d = {24'd0, op_a0_q ? M68K_D_IN[7:0] : M68K_D_IN[15:8]};
                    end else begin
                        rdata_d = {16'd0, M68K_D_IN};
                    end
                end else begin
                    state_d = ST_S6;
                end
            end
            ST_S7: begin
                if (rise_s) begin
                    d_oe_d = 1'b0;
                    rw_d   = 1'b1;
                    if (op_long_q && !half_q && (err_q == 2'd0)) begin
                        state_d = ST_S1;
                        half_d  = 1'b1;
                        a_d     = a_q + 23'd1;
                        d_out_d = op_wlo_q;
                        tmo_d   = {TMO_W{1'b0}};
                    end else begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_q;
                        rsp_rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_S7;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge PI_CLK) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= '{addr: REQ_ADDR, wdata: REQ_WDATA, size: REQ_SIZE,
                                    rw: REQ_RW, fc: REQ_FC};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            clk_sync_q <= '0;      dtack_sync_q <= '1;  berr_sync_q <= '1;  vpa_sync_q <= '1;
            state_q <= ST_IDLE;    wr_ptr_q <= '0;      rd_ptr_q <= '0;     count_q <= '0;
            ready_q <= 1'b1;       busy_q <= 1'b0;      e_cnt_q <= 4'd0;    e_q <= 1'b0;
            vma_n_q <= 1'b1;       as_n_q <= 1'b1;      uds_n_q <= 1'b1;    lds_n_q <= 1'b1;
            rw_q <= 1'b1;          d_oe_q <= 1'b0;      a_q <= 23'd0;       fc_q <= 3'd0;
            d_out_q <= 16'd0;      op_rw_q <= 1'b1;     op_long_q <= 1'b0;  op_byte_q <= 1'b0;
            op_a0_q <= 1'b0;       op_wlo_q <= 16'd0;   half_q <= 1'b0;     err_q <= 2'd0;
            rdata_q <= 32'd0;      tmo_q <= '0;         rsp_valid_q <= 1'b0;
            rsp_err_q <= 2'd0;     rsp_rdata_q <= 32'd0;
        end else begin
            clk_sync_q <= clk_sync_d;  dtack_sync_q <= dtack_sync_d;
            berr_sync_q <= berr_sync_d; vpa_sync_q <= vpa_sync_d;
            state_q <= state_d;    wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
            ready_q <= ready_d;    busy_q <= busy_d;    e_cnt_q <= e_cnt_d; e_q <= e_d;
            vma_n_q <= vma_n_d;    as_n_q <= as_n_d;    uds_n_q <= uds_n_d; lds_n_q <= lds_n_d;
            rw_q <= rw_d;          d_oe_q <= d_oe_d;    a_q <= a_d;         fc_q <= fc_d;
            d_out_q <= d_out_d;    op_rw_q <= op_rw_d;  op_long_q <= op_long_d; op_byte_q <= op_byte_d;
            op_a0_q <= op_a0_d;    op_wlo_q <= op_wlo_d; half_q <= half_d;  err_q <= err_d;
            rdata_q <= rdata_d;    tmo_q <= tmo_d;      rsp_valid_q <= rsp_valid_d;
            rsp_err_q <= rsp_err_d; rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign REQ_READY  = ready_q;
    assign BUSY       = busy_q;
    assign FIFO_LEVEL = count_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ERR    = rsp_err_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign M68K_A     = a_q;
    assign M68K_FC    = fc_q;
    assign M68K_D_OUT = d_out_q;
    assign M68K_D_OE  = d_oe_q;
    assign M68K_AS_n  = as_n_q;
    assign M68K_UDS_n = uds_n_q;
    assign M68K_LDS_n = lds_n_q;
    assign M68K_RW    = rw_q;
    assign M68K_E     = e_q;
    assign M68K_VMA_n = vma_n_q;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed bench for m68k_bus_sequencer: bus-cycle shape, terminations, FIFO limits and reset.
module tb_m68k_bus_sequencer;
    logic        PI_CLK, PI_RST, REQ_VALID, REQ_READY, REQ_RW, RSP_VALID, BUSY;
    logic [23:0] REQ_ADDR;
    logic [31:0] REQ_WDATA, RSP_RDATA;
    logic [1:0]  REQ_SIZE, RSP_ERR;
    logic [2:0]  REQ_FC, M68K_FC, FIFO_LEVEL;
    logic        M68K_CLK, M68K_D_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
    logic [22:0] M68K_A;
    logic [15:0] M68K_D_OUT, M68K_D_IN;
    logic        M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n, M68K_E, M68K_VMA_n;

    int total = 0;
    int bad = 0;

    m68k_bus_sequencer #(.FIFO_DEPTH(4), .SYNC_STAGES(3), .TIMEOUT_CYC(15)) dut (
        .PI_CLK(PI_CLK), .PI_RST(PI_RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_RW(REQ_RW),
        .REQ_FC(REQ_FC), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY), .M68K_CLK(M68K_CLK), .M68K_A(M68K_A),
        .M68K_FC(M68K_FC), .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE), .M68K_D_IN(M68K_D_IN),
        .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW),
        .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n), .M68K_VPA_n(M68K_VPA_n),
        .M68K_E(M68K_E), .M68K_VMA_n(M68K_VMA_n)
    );

    initial PI_CLK = 1'b0;
    always #5 PI_CLK = ~PI_CLK;

    // Bus clock edges sit at 2 mod 10 ns, never on a PI_CLK edge
    initial begin
        M68K_CLK = 1'b0;
        #2;
        forever #40 M68K_CLK = ~M68K_CLK;
    end

    // Bus observer
    int          as_falls, rsp_cnt, mclk_falls_as;
    logic [22:0] a_log[$];
    logic [15:0] d_log[$];
    logic [1:0]  err_log[$];
    logic [31:0] data_log[$];
    logic        uds_seen, lds_seen, strobe_with_as, oe_at_strobe, vma_seen, e_at_vma, e_in_vma;
    logic        prev_as = 1'b1, prev_uds = 1'b1, prev_lds = 1'b1, prev_vma = 1'b1;

    always @(negedge PI_CLK) begin
        logic as_fell;
        as_fell = prev_as && !M68K_AS_n;
        if (as_fell) begin
            as_falls++;
            a_log.push_back(M68K_A);
        end
        if ((prev_uds && !M68K_UDS_n) || (prev_lds && !M68K_LDS_n)) begin
            if (!M68K_RW) d_log.push_back(M68K_D_OUT);
            oe_at_strobe   = M68K_D_OE;
            strobe_with_as = as_fell;
        end
        if (!M68K_UDS_n) uds_seen = 1'b1;
        if (!M68K_LDS_n) lds_seen = 1'b1;
        if (prev_vma && !M68K_VMA_n) begin
            vma_seen = 1'b1;
            e_at_vma = M68K_E;
        end
        if (!M68K_VMA_n && M68K_E) e_in_vma = 1'b1;
        if (RSP_VALID) begin
            rsp_cnt++;
            err_log.push_back(RSP_ERR);
            data_log.push_back(RSP_RDATA);
        end
        prev_as = M68K_AS_n; prev_uds = M68K_UDS_n; prev_lds = M68K_LDS_n; prev_vma = M68K_VMA_n;
    end

    always @(negedge M68K_CLK) if (M68K_AS_n === 1'b0) mclk_falls_as++;

    task automatic clear_mon();
        as_falls = 0; rsp_cnt = 0; mclk_falls_as = 0;
        a_log.delete(); d_log.delete(); err_log.delete(); data_log.delete();
        uds_seen = 1'b0; lds_seen = 1'b0; strobe_with_as = 1'b0; oe_at_strobe = 1'b0;
        vma_seen = 1'b0; e_at_vma = 1'b0; e_in_vma = 1'b0;
    endtask

    // Caller is at a negedge; leaves at the following negedge
    task automatic push(input logic [23:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                        input logic rw, input logic [2:0] fc);
        REQ_ADDR = addr; REQ_WDATA = wdata; REQ_SIZE = size; REQ_RW = rw; REQ_FC = fc;
        REQ_VALID = 1'b1;
        @(negedge PI_CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int cyc = 0;
        while (rsp_cnt < n && cyc < 3000) begin
            @(negedge PI_CLK);
            cyc++;
        end
        repeat (3) @(negedge PI_CLK);
        total++;
        if (rsp_cnt < n) begin
            bad++;
            $display("FAIL %s_rsp_wait: got %0d responses, want %0d", tag, rsp_cnt, n);
        end
    endtask

    task automatic test_reset();
        PI_RST = 1'b1;
        repeat (4) @(negedge PI_CLK);
        total++; if (M68K_AS_n !== 1'b1 || M68K_UDS_n !== 1'b1 || M68K_LDS_n !== 1'b1) begin
            bad++; $display("FAIL rst_strobes_during: got %b%b%b want 111", M68K_AS_n, M68K_UDS_n, M68K_LDS_n); end
        PI_RST = 1'b0;
        repeat (2) @(negedge PI_CLK);
        total++; if ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n} !== 3'b111) begin
            bad++; $display("FAIL rst_strobes: got %b want 111", {M68K_AS_n, M68K_UDS_n, M68K_LDS_n}); end
        total++; if (M68K_VMA_n !== 1'b1 || M68K_RW !== 1'b1) begin
            bad++; $display("FAIL rst_vma_rw: got %b%b want 11", M68K_VMA_n, M68K_RW); end
        total++; if (M68K_D_OE !== 1'b0 || M68K_E !== 1'b0) begin
            bad++; $display("FAIL rst_oe_e: got %b%b want 00", M68K_D_OE, M68K_E); end
        total++; if (RSP_VALID !== 1'b0) begin
            bad++; $display("FAIL rst_rsp_valid: got %b want 0", RSP_VALID); end
        total++; if (FIFO_LEVEL !== 3'd0 || REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL rst_fifo: got level=%0d ready=%b busy=%b want 0 1 0", FIFO_LEVEL, REQ_READY, BUSY); end
    endtask

    task automatic test_word_read();
        clear_mon();
        M68K_DTACK_n = 1'b0; M68K_D_IN = 16'hA5C3;
        push(24'hBFE000, 32'h0, 2'd1, 1'b1, 3'd5);
        wait_rsp(1, "wread");
        total++; if (rsp_cnt !== 1 || err_log[0] !== 2'd0 || data_log[0] !== 32'h0000A5C3) begin
            bad++; $display("FAIL wread_rsp: got cnt=%0d err=%0d data=%h want 1 0 0000a5c3",
                            rsp_cnt, err_log[0], data_log[0]); end
        total++; if (as_falls !== 1 || a_log[0] !== 23'h5FF000) begin
            bad++; $display("FAIL wread_addr: got falls=%0d a=%h want 1 5ff000", as_falls, a_log[0]); end
        total++; if (!uds_seen || !lds_seen || !strobe_with_as) begin
            bad++; $display("FAIL wread_strobes: got uds=%b lds=%b with_as=%b want 111", uds_seen, lds_seen, strobe_with_as); end
        total++; if (mclk_falls_as !== 3) begin
            bad++; $display("FAIL wread_as_width: got %0d bus falls want 3", mclk_falls_as); end
        total++; if (M68K_FC !== 3'd5 || M68K_RW !== 1'b1 || M68K_AS_n !== 1'b1) begin
            bad++; $display("FAIL wread_end: got fc=%0d rw=%b as=%b want 5 1 1", M68K_FC, M68K_RW, M68K_AS_n); end
    endtask

    task automatic test_long_write();
        logic [22:0] a0, a1;
        logic [15:0] d0, d1;
        clear_mon();
        M68K_DTACK_n = 1'b0;
        push(24'h000100, 32'h12345678, 2'd2, 1'b0, 3'd1);
        wait_rsp(1, "lwrite");
        a0 = (a_log.size() > 0) ? a_log[0] : 23'h0;
        a1 = (a_log.size() > 1) ? a_log[1] : 23'h0;
        d0 = (d_log.size() > 0) ? d_log[0] : 16'h0;
        d1 = (d_log.size() > 1) ? d_log[1] : 16'h0;
        total++; if (as_falls !== 2 || a0 !== 23'h80 || a1 !== 23'h81) begin
            bad++; $display("FAIL lwrite_addr: got falls=%0d a=%h,%h want 2 80,81", as_falls, a0, a1); end
        total++; if (d_log.size() !== 2 || d0 !== 16'h1234 || d1 !== 16'h5678) begin
            bad++; $display("FAIL lwrite_data: got n=%0d d=%h,%h want 2 1234,5678", d_log.size(), d0, d1); end
        total++; if (strobe_with_as !== 1'b0 || oe_at_strobe !== 1'b1) begin
            bad++; $display("FAIL lwrite_strobe_timing: got with_as=%b oe=%b want 0 1", strobe_with_as, oe_at_strobe); end
        total++; if (rsp_cnt !== 1 || err_log[0] !== 2'd0) begin
            bad++; $display("FAIL lwrite_rsp: got cnt=%0d err=%0d want 1 0", rsp_cnt, err_log[0]); end
        total++; if (M68K_D_OE !== 1'b0) begin
            bad++; $display("FAIL lwrite_oe_end: got %b want 0", M68K_D_OE); end
    endtask

    task automatic test_byte_read_vpa();
        clear_mon();
        M68K_DTACK_n = 1'b1; M68K_VPA_n = 1'b0; M68K_D_IN = 16'h12AB;
        push(24'h000001, 32'h0, 2'd0, 1'b1, 3'd5);
        wait_rsp(1, "vpa");
        M68K_VPA_n = 1'b1;
        total++; if (rsp_cnt !== 1 || err_log[0] !== 2'd0 || data_log[0] !== 32'h000000AB) begin
            bad++; $display("FAIL vpa_rsp: got cnt=%0d err=%0d data=%h want 1 0 000000ab",
                            rsp_cnt, err_log[0], data_log[0]); end
        total++; if (uds_seen !== 1'b0 || lds_seen !== 1'b1) begin
            bad++; $display("FAIL vpa_strobes: got uds=%b lds=%b want 0 1", uds_seen, lds_seen); end
        total++; if (!vma_seen || e_at_vma !== 1'b0 || !e_in_vma) begin
            bad++; $display("FAIL vpa_vma: got seen=%b e_at=%b e_during=%b want 1 0 1", vma_seen, e_at_vma, e_in_vma); end
        total++; if (M68K_VMA_n !== 1'b1) begin
            bad++; $display("FAIL vpa_vma_end: got %b want 1", M68K_VMA_n); end
    endtask

    task automatic test_timeout();
        clear_mon();
        M68K_DTACK_n = 1'b1;
        push(24'h000200, 32'h0, 2'd1, 1'b1, 3'd2);
        wait_rsp(1, "tmo");
        total++; if (rsp_cnt !== 1 || err_log[0] !== 2'd2) begin
            bad++; $display("FAIL tmo_rsp: got cnt=%0d err=%0d want 1 2", rsp_cnt, err_log[0]); end
        total++; if (mclk_falls_as !== 17) begin
            bad++; $display("FAIL tmo_width: got %0d bus falls want 17", mclk_falls_as); end
        total++; if (M68K_AS_n !== 1'b1) begin
            bad++; $display("FAIL tmo_as_end: got %b want 1", M68K_AS_n); end
    endtask

    task automatic test_berr();
        clear_mon();
        M68K_BERR_n = 1'b0; M68K_DTACK_n = 1'b0;
        push(24'h000300, 32'h0000BEEF, 2'd1, 1'b0, 3'd1);
        push(24'h000400, 32'h0, 2'd2, 1'b1, 3'd1);
        wait_rsp(2, "berr");
        M68K_BERR_n = 1'b1;
        total++; if (rsp_cnt !== 2 || err_log[0] !== 2'd1 || err_log[1] !== 2'd1) begin
            bad++; $display("FAIL berr_rsp: got cnt=%0d err=%0d,%0d want 2 1,1", rsp_cnt, err_log[0], err_log[1]); end
        total++; if (as_falls !== 2) begin
            bad++; $display("FAIL berr_long_skip: got %0d bus cycles want 2", as_falls); end
    endtask

    task automatic test_fifo_full();
        int cyc = 0;
        clear_mon();
        M68K_DTACK_n = 1'b1;
        push(24'h000500, 32'h0, 2'd1, 1'b1, 3'd1);
        while (M68K_AS_n !== 1'b0 && cyc < 200) begin
            @(negedge PI_CLK);
            cyc++;
        end
        total++; if (M68K_AS_n !== 1'b0) begin
            bad++; $display("FAIL fifo_stall: got as=%b want 0", M68K_AS_n); end
        push(24'h000101, 32'h0, 2'd1, 1'b1, 3'd1);
        push(24'h000010, 32'h0, 2'd1, 1'b1, 3'd1);
        push(24'h000020, 32'h000000C7, 2'd0, 1'b0, 3'd1);
        push(24'h000030, 32'h00001111, 2'd1, 1'b0, 3'd1);
        total++; if (REQ_READY !== 1'b0 || FIFO_LEVEL !== 3'd4) begin
            bad++; $display("FAIL fifo_full: got ready=%b level=%0d want 0 4", REQ_READY, FIFO_LEVEL); end
        push(24'h000040, 32'h0, 2'd1, 1'b1, 3'd1);
        total++; if (FIFO_LEVEL !== 3'd4 || BUSY !== 1'b1) begin
            bad++; $display("FAIL fifo_overflow: got level=%0d busy=%b want 4 1", FIFO_LEVEL, BUSY); end
        M68K_DTACK_n = 1'b0;
        wait_rsp(5, "fifo");
        repeat (200) @(negedge PI_CLK);
        total++; if (rsp_cnt !== 5 || as_falls !== 4) begin
            bad++; $display("FAIL fifo_count: got rsp=%0d cycles=%0d want 5 4", rsp_cnt, as_falls); end
        total++; if (err_log[0] !== 2'd0 || err_log[1] !== 2'd3 || err_log[2] !== 2'd0) begin
            bad++; $display("FAIL fifo_misaligned: got err=%0d,%0d,%0d want 0,3,0", err_log[0], err_log[1], err_log[2]); end
        total++; if (FIFO_LEVEL !== 3'd0 || REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL fifo_drain: got level=%0d ready=%b busy=%b want 0 1 0", FIFO_LEVEL, REQ_READY, BUSY); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        clear_mon();
        M68K_DTACK_n = 1'b1;
        push(24'h000600, 32'h0, 2'd1, 1'b1, 3'd1);
        while (M68K_AS_n !== 1'b0 && cyc < 200) begin
            @(negedge PI_CLK);
            cyc++;
        end
        push(24'h000610, 32'h0, 2'd1, 1'b1, 3'd1);
        repeat (30) @(negedge PI_CLK);
        total++; if (M68K_AS_n !== 1'b0 || FIFO_LEVEL !== 3'd1) begin
            bad++; $display("FAIL rstmid_pre: got as=%b level=%0d want 0 1", M68K_AS_n, FIFO_LEVEL); end
        PI_RST = 1'b1;
        @(negedge PI_CLK);
        total++; if ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n} !== 3'b111 || FIFO_LEVEL !== 3'd0) begin
            bad++; $display("FAIL rstmid_strobes: got %b level=%0d want 111 0",
                            {M68K_AS_n, M68K_UDS_n, M68K_LDS_n}, FIFO_LEVEL); end
        PI_RST = 1'b0;
        repeat (300) @(negedge PI_CLK);
        total++; if (rsp_cnt !== 0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL rstmid_dropped: got rsp=%0d busy=%b want 0 0", rsp_cnt, BUSY); end
    endtask

    initial begin
        PI_RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = 24'h0; REQ_WDATA = 32'h0; REQ_SIZE = 2'd0;
        REQ_RW = 1'b1; REQ_FC = 3'd0; M68K_D_IN = 16'h0;
        M68K_DTACK_n = 1'b1; M68K_BERR_n = 1'b1; M68K_VPA_n = 1'b1;
        clear_mon();
        @(negedge PI_CLK);
        test_reset();
        test_word_read();
        test_long_write();
        test_byte_read_vpa();
        test_timeout();
        test_berr();
        test_fifo_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
